pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the MIPS core. It selects the next PC from sequential, branch, jump, jump-register and exception sources. It drives a req/ready handshake to instruction memory and buffers one redirect that arrives while a fetch is outstanding. It replaces the free-running PC register as the front end of the fetch stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; always equals pc.
imem_ready  input  1  memory accepts and returns the word this cycle.
fetch_valid  output  1  combinational; equals imem_req & imem_ready; fetched word is valid.
stall  input  1  pipeline stall; suppresses imem_req.
branch_taken  input  1  take a PC-relative branch.
branch_offset  input  16  signed word offset.
jump  input  1  take an absolute jump.
jump_target  input  26  jump index field.
jr  input  1  take a register jump.
jr_target  input  32  register jump address.
exception  input  1  redirect to EXC_VECTOR.
pc  output  32  current PC.
pc_plus4  output  32  pc + 4, mod 2^32.
epc  output  32  PC captured at exception.
misaligned  output  1  sticky fault on a misaligned jr target.

Behaviour:
- Reset (sync, high): pc = RESET_VECTOR, state = RST, pending cleared, epc = 0, misaligned = 0, imem_req = 0.
- States:
  - RST: imem_req = 0. Next cycle goes to FETCH unless a redirect is applied.
  - FETCH: imem_req = ~stall.
  - HALT: imem_req = 0, misaligned = 1. Stays in HALT until reset; all redirects are ignored.
- Redirect priority, evaluated each cycle: exception > jr > jump > branch_taken. Lower-priority requests in the same cycle are dropped.
- Redirect targets:
  - Branch: pc_plus4 + (sign_extend(branch_offset) << 2), mod 2^32.
  - Jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - Jr: jr_target.
  - Exception: EXC_VECTOR; also epc <= pc on the same edge.
- Jr with jr_target[1:0] != 0, and no exception that cycle: go to HALT, pc unchanged.
- Handshake rules:
  - While imem_req = 1 and imem_ready = 0, pc and imem_addr are held stable.
  - imem_ready is ignored when imem_req = 0.
- PC update at each edge, first match wins:
  1. Acceptance (fetch_valid = 1) with a redirect this cycle: pc <= this-cycle target; pending cleared.
  2. Acceptance with a pending redirect: pc <= pending target; pending cleared.
  3. Acceptance with nothing pending: pc <= pc_plus4.
  4. No acceptance and imem_req = 0 (stall or RST), with a redirect or pending: pc <= target immediately; pending cleared; state = FETCH.
  5. Redirect while imem_req = 1 and not ready: the redirect is stored in the 1-entry pending buffer.
     - If pending is occupied, the incoming redirect replaces it when its priority is higher or equal.
     - A stored exception is only replaced by a newer exception. epc is captured when the exception arrives, not when it is applied.
  6. Otherwise pc holds.
- Wrap: pc = 32'hFFFF_FFFC plus a sequential advance gives 32'h0000_0000. There is no overflow flag.
- Stall asserted mid-wait drops imem_req the same cycle. pc is unchanged and the fetch is retried when stall drops.
- Reset mid-operation overrides everything, including pending, HALT and an outstanding request.

Test Plan:
- Sequential: reset, imem_ready = 1 constantly -> imem_addr 0x0, 0x4, 0x8, 0xC on consecutive cycles; fetch_valid = 1 each cycle after RST.
- Wait states: imem_ready low 3 cycles at pc = 0x8 -> imem_addr held at 0x8, fetch_valid = 0. Then ready -> pc = 0xC next cycle.
- Pending redirect and priority:
  - Branch_taken with offset = 16'hFFFE at pc = 0x10 while waiting -> stored; applied on acceptance: pc = 0x0C.
  - Same-cycle jump 0x0000040 and branch -> pc = 0x0000_0100 (jump wins).
- Exception during stall at pc = 0x20 -> next pc = 0x8000_0180, epc = 0x20. A jr in the same cycle is ignored.
- Misaligned jr_target = 0x1002 -> misaligned = 1, imem_req = 0, pc frozen. Later redirects are ignored; reset clears to pc = 0x0, misaligned = 0.
- Wrap: jr to 0xFFFF_FFFC, accept twice -> imem_addr 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
// Latency: a redirect or sequential advance takes effect on the edge the fetch is accepted (or at once if no fetch is outstanding).
// Backpressure: imem_ready low holds pc/imem_addr; stall drops imem_req; one redirect is buffered while a fetch waits.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   imem_req/imem_addr/imem_ready    fetch handshake to instruction memory
//   fetch_valid                      imem_req & imem_ready
//   stall                            pipeline stall, suppresses imem_req
//   branch_taken/branch_offset       PC-relative branch (signed word offset)
//   jump/jump_target                 absolute jump (26-bit index)
//   jr/jr_target                     register jump
//   exception                        redirect to EXC_VECTOR, captures epc
//   pc, pc_plus4, epc, misaligned    architectural state outputs
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        fetch_valid,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state;

  // Single-entry redirect buffer. Priority code: 3=exception, 2=jr, 1=jump, 0=branch.
  logic        pend_vld;
  logic [1:0]  pend_pri;
  logic [31:0] pend_tgt;

  logic        redir_vld;
  logic [1:0]  redir_pri;
  logic [31:0] redir_tgt;
  logic        jr_bad;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = (state == ST_FETCH) & ~stall;
  assign fetch_valid = imem_req & imem_ready;

  // Highest-priority redirect this cycle; lower ones are simply dropped.
  always_comb begin
    redir_vld = 1'b0;
    redir_pri = 2'd0;
    redir_tgt = pc_plus4;
    if (exception) begin
      redir_vld = 1'b1;
      redir_pri = 2'd3;
      redir_tgt = EXC_VECTOR;
    end else if (jr) begin
      redir_vld = 1'b1;
      redir_pri = 2'd2;
      redir_tgt = jr_target;
    end else if (jump) begin
      redir_vld = 1'b1;
      redir_pri = 2'd1;
      redir_tgt = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      redir_vld = 1'b1;
      redir_pri = 2'd0;
      redir_tgt = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    end
  end

  // A selected jr with a non-word-aligned target is fatal; an exception outranks it.
  assign jr_bad = ~exception & jr & (jr_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RST;
      pc         <= RESET_VECTOR;
      pend_vld   <= 1'b0;
      pend_pri   <= 2'd0;
      pend_tgt   <= 32'd0;
      epc        <= 32'd0;
      misaligned <= 1'b0;
    end else if (state != ST_HALT) begin
      // epc records the faulting pc when the exception arrives, even if it is only buffered.
      if (exception) begin
        epc <= pc;
      end
      if (jr_bad) begin
        state      <= ST_HALT;
        misaligned <= 1'b1;
      end else if (fetch_valid) begin
        if (redir_vld) begin
          pc <= redir_tgt;
        end else if (pend_vld) begin
          pc <= pend_tgt;
        end else begin
          pc <= pc_plus4;
        end
        pend_vld <= 1'b0;
      end else if (!imem_req) begin
        // No fetch outstanding (stalled or leaving RST): redirect immediately.
        if (redir_vld) begin
          pc <= redir_tgt;
        end else if (pend_vld) begin
          pc <= pend_tgt;
        end
        pend_vld <= 1'b0;
        state    <= ST_FETCH;
      end else if (redir_vld && (!pend_vld || (redir_pri >= pend_pri))) begin
        // Fetch waiting on memory: pc must stay put, so park the redirect.
        pend_vld <= 1'b1;
        pend_pri <= redir_pri;
        pend_tgt <= redir_tgt;
      end
    end
  end

endmodule
